// File: rtl/avalon_st_packet_tx_pkg.sv
// -----------------------------------------------------------------------------
// avalon_st_tx_pack
// Shared types and helpers for the Avalon-ST packet transmitter slice.
//   avalon_st_tx_sm_t : transmitter state encoding (IDLE, SEND_MESSAGE)
//   empty_width()     : width of the Avalon-ST empty field for a beat size
//   ceil_words()      : number of beats needed to carry a byte count
// -----------------------------------------------------------------------------
package avalon_st_tx_pack;

   typedef enum logic {
      IDLE         = 1'b0,
      SEND_MESSAGE = 1'b1
   } avalon_st_tx_sm_t;

   // Beat sizes are powers of two and at least 2, so clog2 is at least 1.
   function automatic int unsigned empty_width(input int unsigned dw_bytes);
      return (dw_bytes > 1) ? $clog2(dw_bytes) : 1;
   endfunction

   function automatic int unsigned ceil_words(input int unsigned len_bytes,
                                              input int unsigned dw_bytes);
      return (len_bytes + dw_bytes - 1) / dw_bytes;
   endfunction

endpackage

// File: rtl/avalon_st_packet_tx_if.sv
// -----------------------------------------------------------------------------
// avalon_st_if
// Avalon-ST streaming bundle with ready latency 0.
//   valid, ready : beat handshake (transfer when both high)
//   sop, eop     : start / end of packet markers
//   data         : 8*DATA_WIDTH_IN_BYTES bit beat payload
//   empty        : number of unused bytes in an eop beat
// Modports: master (source drives everything but ready), slave (sink).
// -----------------------------------------------------------------------------
interface avalon_st_if
   import avalon_st_tx_pack::*;
#(
   parameter int DATA_WIDTH_IN_BYTES = 16
);

   localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);

   logic                               valid;
   logic                               ready;
   logic                               sop;
   logic                               eop;
   logic [8*DATA_WIDTH_IN_BYTES-1:0]   data;
   logic [EMPTY_W-1:0]                 empty;

   modport master (
      output valid,
      output sop,
      output eop,
      output data,
      output empty,
      input  ready
   );

   modport slave (
      input  valid,
      input  sop,
      input  eop,
      input  data,
      input  empty,
      output ready
   );

endinterface

// File: rtl/avalon_st_packet_tx_out_stage.sv
// -----------------------------------------------------------------------------
// avalon_st_tx_out_stage
// Single-entry registered Avalon-ST output stage. Holds one beat (data, sop,
// eop, empty) and presents it on msg_out until the sink takes it.
//   clk, rst   : clock, synchronous active-low reset
//   load       : request to capture in_* this cycle
//   in_*       : beat fields to capture
//   can_load   : stage is empty or is being drained this cycle
//   msg_out    : Avalon-ST master side
// -----------------------------------------------------------------------------
module avalon_st_tx_out_stage #(
   parameter int DATA_W  = 128,
   parameter int EMPTY_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_sop,
   input  logic               in_eop,
   input  logic [EMPTY_W-1:0] in_empty,
   output logic               can_load,
   avalon_st_if.master        msg_out
);

   logic load_fire;

   always_comb begin
      can_load  = ~msg_out.valid | msg_out.ready;
      // Gate internally so a stalled beat can never be overwritten.
      load_fire = load & can_load;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         msg_out.valid <= 1'b0;
         msg_out.sop   <= 1'b0;
         msg_out.eop   <= 1'b0;
         msg_out.data  <= '0;
         msg_out.empty <= '0;
      end else if (load_fire) begin
         msg_out.valid <= 1'b1;
         msg_out.sop   <= in_sop;
         msg_out.eop   <= in_eop;
         msg_out.data  <= in_data;
         msg_out.empty <= in_empty;
      end else if (msg_out.ready) begin
         msg_out.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/avalon_st_packet_tx.sv
// -----------------------------------------------------------------------------
// avalon_st_packet_tx
// Avalon-ST packet source. Accepts a byte-length command, then consumes
// ceil(len/DW) raw data words and emits them as one well-formed packet with
// sop on the first beat, eop on the last and empty marking unused bytes.
//   clk, rst        : clock, synchronous active-low reset
//   cmd_valid/ready : packet command handshake, cmd_len = length in bytes
//   data_valid/ready: raw data word handshake, data_in = word
//   msg_out         : Avalon-ST master output (registered, ready latency 0)
//   len_zero_error  : one-cycle pulse when a zero-length command is rejected
//   busy            : packet in progress or output register occupied
// -----------------------------------------------------------------------------
module avalon_st_packet_tx
   import avalon_st_tx_pack::*;
#(
   parameter int DATA_WIDTH_IN_BYTES = 16,
   parameter int LEN_W               = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [LEN_W-1:0]                  cmd_len,
   input  logic                              data_valid,
   output logic                              data_ready,
   input  logic [8*DATA_WIDTH_IN_BYTES-1:0]  data_in,
   avalon_st_if.master                       msg_out,
   output logic                              len_zero_error,
   output logic                              busy
);

   localparam int DATA_W  = 8 * DATA_WIDTH_IN_BYTES;
   localparam int EMPTY_W = empty_width(DATA_WIDTH_IN_BYTES);
   localparam int WORDS_W = $clog2(ceil_words((1 << LEN_W) - 1, DATA_WIDTH_IN_BYTES) + 1);
   localparam logic [LEN_W:0] ROUND_ADD = (LEN_W + 1)'(DATA_WIDTH_IN_BYTES - 1);

   avalon_st_tx_sm_t state, state_next;

   logic [WORDS_W-1:0] words_left;
   logic [EMPTY_W-1:0] last_empty;
   logic               first_beat;

   logic [LEN_W:0]     len_round;
   logic [WORDS_W-1:0] cmd_words;
   logic [EMPTY_W-1:0] cmd_empty;
   logic               cmd_fire;
   logic               cmd_nonzero;
   logic               load;
   logic               can_load;
   logic               beat_eop;
   logic [EMPTY_W-1:0] beat_empty;

   // Command decode. The extra bit in len_round keeps the round-up free of
   // overflow at the maximum length; empty = (DW - len mod DW) mod DW is the
   // two's-complement negation of the low length bits.
   always_comb begin
      len_round   = {1'b0, cmd_len} + ROUND_ADD;
      cmd_words   = WORDS_W'(len_round >> EMPTY_W);
      cmd_empty   = EMPTY_W'(0) - cmd_len[EMPTY_W-1:0];
      cmd_nonzero = (cmd_len != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      data_ready = 1'b0;
      cmd_fire   = 1'b0;
      load       = 1'b0;
      beat_eop   = (words_left == WORDS_W'(1));
      beat_empty = beat_eop ? last_empty : '0;
      case (state)
         IDLE: begin
            cmd_ready = rst;
            cmd_fire  = cmd_valid & rst;
            if (cmd_fire && cmd_nonzero) begin
               state_next = SEND_MESSAGE;
            end
         end
         SEND_MESSAGE: begin
            data_ready = can_load;
            load       = data_valid & can_load;
            if (load && beat_eop) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         words_left     <= '0;
         last_empty     <= '0;
         first_beat     <= 1'b0;
         len_zero_error <= 1'b0;
      end else begin
         len_zero_error <= cmd_fire & ~cmd_nonzero;
         if (cmd_fire && cmd_nonzero) begin
            words_left <= cmd_words;
            last_empty <= cmd_empty;
            first_beat <= 1'b1;
         end else if (load) begin
            first_beat <= 1'b0;
            words_left <= words_left - WORDS_W'(1);
         end
      end
   end

   avalon_st_tx_out_stage #(
      .DATA_W  (DATA_W),
      .EMPTY_W (EMPTY_W)
   ) u_out_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .in_data  (data_in),
      .in_sop   (first_beat),
      .in_eop   (beat_eop),
      .in_empty (beat_empty),
      .can_load (can_load),
      .msg_out  (msg_out)
   );

   assign busy = (state == SEND_MESSAGE) | msg_out.valid;

endmodule
